// File: rtl/junction_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : junction_pkg
//  Description : Shared encodings for the junction phase scheduler: phase
//                states, per-approach light codes and approach indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package junction_pkg;

    // Phase encodings
    localparam logic [2:0] ST_ALLRED = 3'd0;
    localparam logic [2:0] ST_GREEN  = 3'd1;
    localparam logic [2:0] ST_YELLOW = 3'd2;
    localparam logic [2:0] ST_PED    = 3'd3;
    localparam logic [2:0] ST_EMERG  = 3'd4;

    // Light codes
    localparam logic [1:0] LT_RED    = 2'b00;
    localparam logic [1:0] LT_YELLOW = 2'b01;
    localparam logic [1:0] LT_GREEN  = 2'b10;

    // Approach indices
    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    // Light code shown on one approach for a given phase and owning direction
    function automatic logic [1:0] light_code(input logic [2:0] st,
                                              input logic [1:0] owner,
                                              input logic [1:0] approach);
        logic [1:0] code;
        code = LT_RED;
        if (owner == approach) begin
            if (st == ST_GREEN || st == ST_EMERG) begin
                code = LT_GREEN;
            end else if (st == ST_YELLOW) begin
                code = LT_YELLOW;
            end
        end
        return code;
    endfunction

endpackage : junction_pkg
`default_nettype wire

// File: rtl/junction_phase_scheduler_rr_next_dir.sv
`default_nettype none
// ============================================================================
//  Module      : rr_next_dir
//  Description : Round-robin approach selector. Returns the first approach
//                with demand, searching from i_dir+1 around to i_dir itself;
//                falls back to i_dir+1 when nobody is waiting.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_next_dir
    import junction_pkg::*;
(
    input  logic [1:0] i_dir,
    input  logic [3:0] i_demand,
    output logic [1:0] o_next_dir
);

    logic       w_found;
    logic [1:0] w_cand;

    // Scan the four candidates in rotation order, keeping the first hit
    always_comb begin
        w_found    = 1'b0;
        w_cand     = '0;
        o_next_dir = i_dir + 2'd1;
        for (int k = 1; k <= 4; k++) begin
            w_cand = i_dir + 2'(k);
            if (!w_found && i_demand[w_cand]) begin
                w_found    = 1'b1;
                o_next_dir = w_cand;
            end
        end
    end

endmodule : rr_next_dir
`default_nettype wire

// File: rtl/junction_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : junction_phase_scheduler
//  Description : Four-approach junction sequencer. Cycles GREEN -> YELLOW ->
//                ALLRED with per-approach green times, serves latched
//                pedestrian and emergency requests as dedicated phases, and
//                drives registered phase/direction/countdown/light outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module junction_phase_scheduler
    import junction_pkg::*;
#(
    parameter int CW       = 8,
    parameter int YEL_T    = 2,
    parameter int ALLRED_T = 1,
    parameter int PED_T    = 5,
    parameter int EM_T     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          ped_button,
    input  logic          em_button,
    input  logic [1:0]    em_dir,
    input  logic [3:0]    demand,
    input  logic [CW-1:0] tg0,
    input  logic [CW-1:0] tg1,
    input  logic [CW-1:0] tg2,
    input  logic [CW-1:0] tg3,
    output logic [2:0]    state,
    output logic [1:0]    dir,
    output logic [CW-1:0] count,
    output logic [1:0]    n_light,
    output logic [1:0]    e_light,
    output logic [1:0]    s_light,
    output logic [1:0]    w_light,
    output logic          ped_walk,
    output logic          em_active
);

    // Phase load values; a zero duration still occupies one tick
    localparam logic [CW-1:0] c_YEL_LD    = CW'((YEL_T    < 1) ? 1 : YEL_T);
    localparam logic [CW-1:0] c_ALLRED_LD = CW'((ALLRED_T < 1) ? 1 : ALLRED_T);
    localparam logic [CW-1:0] c_PED_LD    = CW'((PED_T    < 1) ? 1 : PED_T);
    localparam logic [CW-1:0] c_EM_LD     = CW'((EM_T     < 1) ? 1 : EM_T);

    logic          r_ped_q;
    logic          r_em_q;
    logic          r_ped_pending;
    logic          r_em_pending;
    logic [1:0]    r_em_dir;

    logic          w_ped_rise;
    logic          w_em_rise;
    logic [1:0]    w_rr_dir;
    logic [CW-1:0] w_tg [4];
    logic [CW-1:0] w_green_ld;
    logic          w_adv;
    logic          w_dec;
    logic          w_enter;
    logic [2:0]    w_tgt;
    logic [2:0]    w_nst;
    logic [1:0]    w_ndir;
    logic [CW-1:0] w_ncnt;
    logic          w_nact;
    logic          w_ped_clr;
    logic          w_em_clr;
    logic [1:0]    w_nlight [4];

    assign w_ped_rise = ped_button & ~r_ped_q;
    assign w_em_rise  = em_button  & ~r_em_q;

    assign w_tg[0] = tg0;
    assign w_tg[1] = tg1;
    assign w_tg[2] = tg2;
    assign w_tg[3] = tg3;

    // Green time of the approach about to be served, sampled only at entry
    assign w_green_ld = (w_tg[w_rr_dir] == '0) ? CW'(1) : w_tg[w_rr_dir];

    assign w_adv = tick && (count == CW'(1));
    assign w_dec = tick && (count >  CW'(1));

    rr_next_dir u_rr_next_dir (
        .i_dir      (dir),
        .i_demand   (demand),
        .o_next_dir (w_rr_dir)
    );

    // Choose the phase to enter: emergency preemption first, then the tick-driven sequence
    always_comb begin
        w_enter = 1'b0;
        w_tgt   = ST_ALLRED;
        case (state)
            ST_GREEN: begin
                if (r_em_pending) begin
                    w_enter = 1'b1;
                    w_tgt   = (dir == r_em_dir) ? ST_EMERG : ST_YELLOW;
                end else if (w_adv) begin
                    w_enter = 1'b1;
                    w_tgt   = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (w_adv) begin
                    w_enter = 1'b1;
                    w_tgt   = ST_ALLRED;
                end
            end
            ST_ALLRED: begin
                if (w_adv) begin
                    w_enter = 1'b1;
                    if (r_em_pending) begin
                        w_tgt = ST_EMERG;
                    end else if (r_ped_pending) begin
                        w_tgt = ST_PED;
                    end else begin
                        w_tgt = ST_GREEN;
                    end
                end
            end
            ST_PED: begin
                if (r_em_pending || w_adv) begin
                    w_enter = 1'b1;
                    w_tgt   = ST_ALLRED;
                end
            end
            ST_EMERG: begin
                if (w_adv) begin
                    w_enter = 1'b1;
                    w_tgt   = ST_YELLOW;
                end
            end
            default: begin
                w_enter = 1'b1;
                w_tgt   = ST_ALLRED;
            end
        endcase
    end

    // Work out next-cycle phase, owner, countdown and request clears
    always_comb begin
        w_nst     = state;
        w_ndir    = dir;
        w_ncnt    = count;
        w_nact    = em_active;
        w_ped_clr = 1'b0;
        w_em_clr  = 1'b0;
        if (w_enter) begin
            w_nst = w_tgt;
            case (w_tgt)
                ST_GREEN: begin
                    w_ndir = w_rr_dir;
                    w_ncnt = w_green_ld;
                    w_nact = 1'b0;
                end
                ST_YELLOW: begin
                    w_ncnt = c_YEL_LD;
                end
                ST_PED: begin
                    w_ncnt    = c_PED_LD;
                    w_ped_clr = 1'b1;
                    w_nact    = 1'b0;
                end
                ST_EMERG: begin
                    w_ndir   = r_em_dir;
                    w_ncnt   = c_EM_LD;
                    w_em_clr = 1'b1;
                    w_nact   = 1'b1;
                end
                default: begin
                    w_ncnt = c_ALLRED_LD;
                end
            endcase
        end else if (w_dec) begin
            w_ncnt = count - CW'(1);
        end
    end

    // Per-approach light code for the upcoming phase
    generate
        for (genvar d = 0; d < 4; d++) begin : g_light
            assign w_nlight[d] = light_code(w_nst, w_ndir, 2'(d));
        end
    endgenerate

    // Button edge detection and request latching
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ped_q       <= 1'b0;
            r_em_q        <= 1'b0;
            r_ped_pending <= 1'b0;
            r_em_pending  <= 1'b0;
            r_em_dir      <= DIR_N;
        end else begin
            r_ped_q <= ped_button;
            r_em_q  <= em_button;
            if (w_ped_clr) begin
                r_ped_pending <= 1'b0;
            end else if (w_ped_rise && state != ST_PED) begin
                r_ped_pending <= 1'b1;
            end
            if (w_em_clr) begin
                r_em_pending <= 1'b0;
            end else if (w_em_rise && !r_em_pending && state != ST_EMERG) begin
                r_em_pending <= 1'b1;
                r_em_dir     <= em_dir;
            end
        end
    end

    // Phase state machine and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_ALLRED;
            dir       <= DIR_N;
            count     <= c_ALLRED_LD;
            n_light   <= LT_RED;
            e_light   <= LT_RED;
            s_light   <= LT_RED;
            w_light   <= LT_RED;
            ped_walk  <= 1'b0;
            em_active <= 1'b0;
        end else begin
            state     <= w_nst;
            dir       <= w_ndir;
            count     <= w_ncnt;
            n_light   <= w_nlight[0];
            e_light   <= w_nlight[1];
            s_light   <= w_nlight[2];
            w_light   <= w_nlight[3];
            ped_walk  <= (w_nst == ST_PED);
            em_active <= w_nact;
        end
    end

endmodule : junction_phase_scheduler
`default_nettype wire

// File: tb/tb_junction_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_junction_phase_scheduler
//  Description : Randomized self-checking bench for junction_phase_scheduler
//                against a phase-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_junction_phase_scheduler;

    localparam int CW = 8;
    localparam int YEL_T = 2, ALLRED_T = 1, PED_T = 5, EM_T = 8;
    localparam int P_ALLRED = 0, P_GREEN = 1, P_YELLOW = 2, P_PED = 3, P_EMERG = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic          ped_button;
    logic          em_button;
    logic [1:0]    em_dir;
    logic [3:0]    demand;
    logic [CW-1:0] tg [4];
    logic [2:0]    state;
    logic [1:0]    dir;
    logic [CW-1:0] count;
    logic [1:0]    n_light, e_light, s_light, w_light;
    logic          ped_walk;
    logic          em_active;

    int n_chk = 0;
    int n_err = 0;

    // Reference model of the junction at phase level
    int m_phase, m_dir, m_left, m_emdir;
    bit m_ped_req, m_em_req, m_em_mode, m_ped_prev, m_em_prev;

    always #5 clk = ~clk;

    junction_phase_scheduler #(
        .CW(CW), .YEL_T(YEL_T), .ALLRED_T(ALLRED_T), .PED_T(PED_T), .EM_T(EM_T)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .ped_button(ped_button), .em_button(em_button), .em_dir(em_dir),
        .demand(demand), .tg0(tg[0]), .tg1(tg[1]), .tg2(tg[2]), .tg3(tg[3]),
        .state(state), .dir(dir), .count(count),
        .n_light(n_light), .e_light(e_light), .s_light(s_light), .w_light(w_light),
        .ped_walk(ped_walk), .em_active(em_active)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int at_least_one(input int t);
        return (t < 1) ? 1 : t;
    endfunction

    // First approach after d (wrapping to d itself) that has a waiting vehicle
    function automatic int next_green(input int d, input logic [3:0] dm);
        for (int k = 1; k <= 4; k++) begin
            if (dm[(d + k) % 4]) return (d + k) % 4;
        end
        return (d + 1) % 4;
    endfunction

    task automatic model_reset();
        m_phase = P_ALLRED; m_dir = 0; m_left = at_least_one(ALLRED_T);
        m_emdir = 0; m_ped_req = 0; m_em_req = 0; m_em_mode = 0;
        m_ped_prev = 0; m_em_prev = 0;
    endtask

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_step();
        int  go;
        bit  ped_edge, em_edge;
        int  old_phase;
        old_phase = m_phase;
        ped_edge  = ped_button && !m_ped_prev;
        em_edge   = em_button && !m_em_prev;
        go = -1;
        if (m_phase == P_GREEN && m_em_req)
            go = (m_dir == m_emdir) ? P_EMERG : P_YELLOW;
        else if (m_phase == P_PED && m_em_req)
            go = P_ALLRED;
        else if (tick) begin
            if (m_left > 1) m_left--;
            else begin
                case (m_phase)
                    P_GREEN:  go = P_YELLOW;
                    P_YELLOW: go = P_ALLRED;
                    P_PED:    go = P_ALLRED;
                    P_EMERG:  go = P_YELLOW;
                    default:  go = m_em_req ? P_EMERG : (m_ped_req ? P_PED : P_GREEN);
                endcase
            end
        end
        // Requests seen this edge are latched before any clear from the new phase
        if (ped_edge && old_phase != P_PED) m_ped_req = 1;
        if (em_edge && !m_em_req && old_phase != P_EMERG) begin
            m_em_req = 1;
            m_emdir  = em_dir;
        end
        if (go >= 0) begin
            m_phase = go;
            case (go)
                P_GREEN: begin
                    m_dir = next_green(m_dir, demand);
                    m_left = at_least_one(tg[m_dir]);
                    m_em_mode = 0;
                end
                P_YELLOW: m_left = at_least_one(YEL_T);
                P_ALLRED: m_left = at_least_one(ALLRED_T);
                P_PED: begin
                    m_left = at_least_one(PED_T);
                    m_ped_req = 0;
                    m_em_mode = 0;
                end
                default: begin
                    m_dir = m_emdir;
                    m_left = at_least_one(EM_T);
                    m_em_req = 0;
                    m_em_mode = 1;
                end
            endcase
        end
        m_ped_prev = ped_button;
        m_em_prev  = em_button;
    endtask

    task automatic compare_all();
        logic [7:0] exp_l;
        int lit;
        exp_l = '0;
        for (int d = 0; d < 4; d++) begin
            logic [1:0] code;
            code = 2'b00;
            if (d == m_dir && (m_phase == P_GREEN || m_phase == P_EMERG)) code = 2'b10;
            if (d == m_dir && m_phase == P_YELLOW) code = 2'b01;
            exp_l[2*(3-d) +: 2] = code;
        end
        chk("state", state, m_phase);
        chk("dir", dir, m_dir);
        chk("count", count, m_left);
        chk("lights", {n_light, e_light, s_light, w_light}, exp_l);
        chk("ped_walk", ped_walk, (m_phase == P_PED));
        chk("em_active", em_active, m_em_mode);
        lit = (n_light != 0) + (e_light != 0) + (s_light != 0) + (w_light != 0);
        chk("one_lit", (lit <= 1), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, state, P_ALLRED);
        chk({tag, "_dir"}, dir, 0);
        chk({tag, "_count"}, count, ALLRED_T);
        chk({tag, "_lights"}, {n_light, e_light, s_light, w_light}, 0);
        chk({tag, "_walk"}, ped_walk, 0);
        chk({tag, "_emact"}, em_active, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
    endtask

    // Drive one cycle of inputs for a stimulus profile
    task automatic drive(input int prof);
        case (prof)
            0: begin
                tick = 1; demand = 4'b1111; ped_button = 0; em_button = 0;
                for (int i = 0; i < 4; i++) tg[i] = 8'd6;
            end
            1: begin
                tick = ($urandom_range(0, 1) == 1);
                demand = 4'($urandom);
                ped_button = ($urandom_range(0, 99) < 4);
                em_button = ($urandom_range(0, 99) < 2);
                em_dir = 2'($urandom);
                if ($urandom_range(0, 19) == 0) tg[$urandom_range(0, 3)] = 8'($urandom_range(0, 9));
            end
            2: begin
                tick = 1;
                demand = ($urandom_range(0, 2) == 0) ? 4'b0000 : (4'b0001 << $urandom_range(0, 3));
                ped_button = ($urandom_range(0, 99) < 10);
                em_button = ($urandom_range(0, 99) < 6);
                em_dir = 2'($urandom);
            end
            3: begin
                tick = ($urandom_range(0, 3) != 0);
                demand = 4'($urandom);
                ped_button = ($urandom_range(0, 99) < 8);
                em_button = ped_button;
                em_dir = ($urandom_range(0, 1) == 1) ? dir : 2'($urandom);
            end
            default: begin
                tick = ($urandom_range(0, 3) == 0);
                demand = 4'($urandom);
                ped_button = ($urandom_range(0, 99) < 15);
                em_button = ($urandom_range(0, 99) < 15);
                em_dir = 2'($urandom);
                for (int i = 0; i < 4; i++) tg[i] = 8'($urandom_range(0, 4));
            end
        endcase
    endtask

    initial begin
        int found;
        reset = 0; tick = 0; ped_button = 0; em_button = 0; em_dir = 0; demand = 0;
        for (int i = 0; i < 4; i++) tg[i] = 8'd6;
        model_reset();
        @(posedge clk); #1;
        check_reset_outputs("por");
        @(negedge clk);
        reset = 1;

        for (int prof = 0; prof < 5; prof++) begin
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                drive(prof);
                step();
            end
        end

        // Reach a YELLOW phase, then pull reset mid-phase with the timebase stopped
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            drive(0);
            step();
            if (m_phase == P_YELLOW) found = 1;
        end
        chk("wait_yellow", found, 1);
        @(negedge clk);
        tick = 0; ped_button = 1; em_button = 0;
        #1 reset = 0;
        #1 check_reset_outputs("async_rst");
        @(posedge clk); #1;
        check_reset_outputs("held_rst");
        @(negedge clk);
        reset = 1;
        ped_button = 0;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            drive(c < 40 ? 0 : 1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_junction_phase_scheduler
`default_nettype wire
